// File: rtl/uart_arb_pkg.sv
// Shared types and constants for the round-robin UART transmit arbiter.
// Holds the FSM state encoding, counter width and a saturating increment helper.
package uart_arb_pkg;

  localparam int CNT_W       = 16;
  localparam int DEF_NUM_REQ = 4;
  localparam int DEF_DW      = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    SEND = 2'd2,
    GAP  = 2'd3
  } arb_state_e;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    if (v == {CNT_W{1'b1}}) begin
      sat_inc = v;
    end else begin
      sat_inc = v + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  endfunction

endpackage

// File: rtl/uart_rr_pick.sv
// Combinational round-robin picker: returns the first set mask bit found
// searching upward from last_id+1, wrapping modulo NUM_REQ.
module uart_rr_pick
  import uart_arb_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int IW      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] mask,
  input  logic [IW-1:0]      last_id,
  output logic               valid,
  output logic [IW-1:0]      id
);

  logic [IW-1:0] idx_s;

  // Scan from farthest to nearest so the nearest eligible requester is written last.
  always_comb begin
    valid = 1'b0;
    id    = {IW{1'b0}};
    idx_s = {IW{1'b0}};
    for (int i = NUM_REQ; i >= 1; i--) begin
      idx_s = IW'((int'(last_id) + i) % NUM_REQ);
      if (mask[idx_s]) begin
        valid = 1'b1;
        id    = idx_s;
      end else begin
        valid = valid;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one UART transmitter among NUM_REQ requesters with round-robin
// arbitration, a per-byte done timeout and a programmable inter-byte gap.
module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int DW      = DEF_DW,
  localparam int IW     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                  pclk_i,
  input  logic                  prst_ni,
  input  logic [NUM_REQ-1:0]    req_i,
  input  logic [NUM_REQ*DW-1:0] data_i,
  input  logic [NUM_REQ-1:0]    chan_en_i,
  input  logic [CNT_W-1:0]      gap_i,
  input  logic [CNT_W-1:0]      timeout_i,
  input  logic                  tx_done_i,
  output logic [NUM_REQ-1:0]    gnt_o,
  output logic                  tx_en_o,
  output logic [DW-1:0]         tx_data_o,
  output logic [IW-1:0]         cur_id_o,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  err_o
);

  arb_state_e          state_r, state_s;
  logic [NUM_REQ-1:0]  gnt_r, gnt_s;
  logic                tx_en_r, tx_en_s;
  logic                done_r, done_s;
  logic                err_r, err_s;
  logic                busy_r, busy_s;
  logic [DW-1:0]       tx_data_r, tx_data_s;
  logic [IW-1:0]       cur_id_r, cur_id_s;
  logic [CNT_W-1:0]    tcnt_r, tcnt_s;
  logic [CNT_W-1:0]    tout_r, tout_s;
  logic [CNT_W-1:0]    gcnt_r, gcnt_s;
  logic [CNT_W-1:0]    glen_r, glen_s;
  logic                pick_valid_s;
  logic [IW-1:0]       pick_id_s;

  uart_rr_pick #(.NUM_REQ(NUM_REQ), .IW(IW)) u_pick (
    .mask    (req_i & chan_en_i),
    .last_id (cur_id_r),
    .valid   (pick_valid_s),
    .id      (pick_id_s)
  );

  // Next-state and registered-output computation; timeout is latched at grant
  // so later changes to timeout_i cannot disturb the byte in flight.
  always_comb begin
    state_s   = state_r;
    gnt_s     = {NUM_REQ{1'b0}};
    tx_en_s   = 1'b0;
    done_s    = 1'b0;
    err_s     = 1'b0;
    tx_data_s = tx_data_r;
    cur_id_s  = cur_id_r;
    tcnt_s    = tcnt_r;
    tout_s    = tout_r;
    gcnt_s    = gcnt_r;
    glen_s    = glen_r;
    case (state_r)
      IDLE: begin
        if (pick_valid_s) begin
          gnt_s     = {{(NUM_REQ-1){1'b0}}, 1'b1} << pick_id_s;
          tx_data_s = data_i[int'(pick_id_s)*DW +: DW];
          cur_id_s  = pick_id_s;
          tout_s    = timeout_i;
          state_s   = LOAD;
        end else begin
          state_s   = IDLE;
        end
      end
      LOAD: begin
        tx_en_s = 1'b1;
        tcnt_s  = {CNT_W{1'b0}};
        state_s = SEND;
      end
      SEND: begin
        tcnt_s = sat_inc(tcnt_r);
        // Done takes priority over a timeout expiring on the same clock.
        if (tx_done_i) begin
          done_s = 1'b1;
          if (gap_i == {CNT_W{1'b0}}) begin
            state_s = IDLE;
          end else begin
            glen_s  = gap_i;
            gcnt_s  = {CNT_W{1'b0}};
            state_s = GAP;
          end
        end else if ((tout_r != {CNT_W{1'b0}}) && (tcnt_s == tout_r)) begin
          err_s   = 1'b1;
          state_s = IDLE;
        end else begin
          state_s = SEND;
        end
      end
      GAP: begin
        gcnt_s = sat_inc(gcnt_r);
        if (gcnt_s >= glen_r) begin
          state_s = IDLE;
        end else begin
          state_s = GAP;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
    busy_s = (state_s != IDLE);
  end

  // State and output registers.
  always_ff @(posedge pclk_i or negedge prst_ni) begin
    if (!prst_ni) begin
      state_r   <= IDLE;
      gnt_r     <= {NUM_REQ{1'b0}};
      tx_en_r   <= 1'b0;
      done_r    <= 1'b0;
      err_r     <= 1'b0;
      busy_r    <= 1'b0;
      tx_data_r <= {DW{1'b0}};
      cur_id_r  <= IW'(NUM_REQ - 1);
      tcnt_r    <= {CNT_W{1'b0}};
      tout_r    <= {CNT_W{1'b0}};
      gcnt_r    <= {CNT_W{1'b0}};
      glen_r    <= {CNT_W{1'b0}};
    end else begin
      state_r   <= state_s;
      gnt_r     <= gnt_s;
      tx_en_r   <= tx_en_s;
      done_r    <= done_s;
      err_r     <= err_s;
      busy_r    <= busy_s;
      tx_data_r <= tx_data_s;
      cur_id_r  <= cur_id_s;
      tcnt_r    <= tcnt_s;
      tout_r    <= tout_s;
      gcnt_r    <= gcnt_s;
      glen_r    <= glen_s;
    end
  end

  assign gnt_o     = gnt_r;
  assign tx_en_o   = tx_en_r;
  assign done_o    = done_r;
  assign err_o     = err_r;
  assign busy_o    = busy_r;
  assign tx_data_o = tx_data_r;
  assign cur_id_o  = cur_id_r;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter: stimulus pushes expected grant/done/err
// events into a queue; a negedge monitor pops and compares as the DUT emits them.
module tb_uart_tx_arbiter;

  localparam int EV_GNT  = 0;
  localparam int EV_DONE = 1;
  localparam int EV_ERR  = 2;

  typedef struct {
    int         kind;
    int         id;
    logic [7:0] data;
  } ev_t;

  logic        pclk_i = 1'b0;
  logic        prst_ni = 1'b0;
  logic [3:0]  req_i = 4'd0;
  logic [31:0] data_i = 32'd0;
  logic [3:0]  chan_en_i = 4'd0;
  logic [15:0] gap_i = 16'd0;
  logic [15:0] timeout_i = 16'd0;
  logic        tx_done_i = 1'b0;
  logic [3:0]  gnt_o;
  logic        tx_en_o;
  logic [7:0]  tx_data_o;
  logic [1:0]  cur_id_o;
  logic        busy_o, done_o, err_o;

  ev_t exp_q[$];
  int  n_checks = 0;
  int  n_errors = 0;

  uart_tx_arbiter #(.NUM_REQ(4), .DW(8)) dut (
    .pclk_i(pclk_i), .prst_ni(prst_ni), .req_i(req_i), .data_i(data_i),
    .chan_en_i(chan_en_i), .gap_i(gap_i), .timeout_i(timeout_i),
    .tx_done_i(tx_done_i), .gnt_o(gnt_o), .tx_en_o(tx_en_o),
    .tx_data_o(tx_data_o), .cur_id_o(cur_id_o), .busy_o(busy_o),
    .done_o(done_o), .err_o(err_o)
  );

  always #5 pclk_i = ~pclk_i;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", n_checks, n_errors);
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic push(input int kind, input int id, input logic [7:0] data);
    ev_t e;
    e.kind = kind; e.id = id; e.data = data;
    exp_q.push_back(e);
  endtask

  task automatic expect_ev(input int kind, input int id, input logic [7:0] data);
    ev_t e;
    n_checks++;
    if (exp_q.size() == 0) begin
      n_errors++;
      $display("FAIL unexpected_event: got kind=%0d id=%0d data=%0h, expected none", kind, id, data);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != kind || (kind == EV_GNT && (e.id != id || e.data != data))) begin
        n_errors++;
        $display("FAIL event_order: got kind=%0d id=%0d data=%0h, expected kind=%0d id=%0d data=%0h",
                 kind, id, data, e.kind, e.id, e.data);
      end
    end
  endtask

  // Monitor: compare every grant/done/err the DUT presents against the queue.
  initial begin
    logic [3:0] prev_gnt;
    int gid;
    prev_gnt = 4'd0;
    forever begin
      @(negedge pclk_i);
      if (prst_ni) begin
        if (gnt_o != 4'd0) begin
          chk("gnt_onehot", 32'($onehot(gnt_o)), 32'd1);
          gid = 0;
          for (int k = 0; k < 4; k++) if (gnt_o[k]) gid = k;
          chk("cur_id", 32'(cur_id_o), 32'(gid));
          expect_ev(EV_GNT, gid, tx_data_o);
        end
        if (tx_en_o) chk("tx_en_latency", 32'(prev_gnt != 4'd0), 32'd1);
        prev_gnt = gnt_o;
        if (done_o) expect_ev(EV_DONE, 0, 8'd0);
        if (err_o) expect_ev(EV_ERR, 0, 8'd0);
      end else begin
        prev_gnt = 4'd0;
      end
    end
  end

  task automatic do_reset();
    @(negedge pclk_i);
    prst_ni = 1'b0;
    #1;
    chk("rst_busy", 32'(busy_o), 32'd0);
    chk("rst_cur_id", 32'(cur_id_o), 32'd3);
    chk("rst_tx_data", 32'(tx_data_o), 32'd0);
    chk("rst_pulses", 32'({gnt_o, tx_en_o, done_o, err_o}), 32'd0);
    repeat (2) @(negedge pclk_i);
    prst_ni = 1'b1;
    chk("queue_empty_at_reset", 32'(exp_q.size()), 32'd0);
    exp_q.delete();
  endtask

  // Serve one byte: wait for grant, optionally drop the request, wait for
  // tx_en_o, then after done_dly clocks pulse tx_done_i (if give_done).
  task automatic run_byte(input int done_dly, input bit give_done, input bit drop);
    int n;
    n = 0;
    while (gnt_o == 4'd0 && n < 40) begin @(negedge pclk_i); n++; end
    if (n >= 40) chk("gnt_wait_timeout", 32'd1, 32'd0);
    if (drop) req_i = req_i & ~gnt_o;
    n = 0;
    while (!tx_en_o && n < 10) begin @(negedge pclk_i); n++; end
    if (n >= 10) chk("tx_en_wait_timeout", 32'd1, 32'd0);
    if (give_done) begin
      repeat (done_dly) @(negedge pclk_i);
      tx_done_i = 1'b1;
      @(negedge pclk_i);
      tx_done_i = 1'b0;
      chk("done_latency", 32'(done_o), 32'd1);
      chk("done_no_err", 32'(err_o), 32'd0);
    end
  endtask

  initial begin
    int n;
    chan_en_i = 4'hF;
    data_i = {8'h44, 8'h33, 8'h22, 8'hA5};
    do_reset();

    // tx_done_i while idle must be ignored (monitor flags any done_o).
    @(negedge pclk_i); tx_done_i = 1'b1;
    @(negedge pclk_i); tx_done_i = 1'b0;
    repeat (2) @(negedge pclk_i);

    // Single byte from requester 0, no gap.
    push(EV_GNT, 0, 8'hA5); push(EV_DONE, 0, 8'd0);
    req_i = 4'b0001;
    run_byte(2, 1'b1, 1'b1);
    chk("busy_after_done_gap0", 32'(busy_o), 32'd0);
    repeat (3) @(negedge pclk_i);

    // All requesting and enabled: strict rotation 0,1,2,3,0.
    do_reset();
    data_i = {8'h44, 8'h33, 8'h22, 8'h11};
    push(EV_GNT, 0, 8'h11); push(EV_DONE, 0, 8'd0);
    push(EV_GNT, 1, 8'h22); push(EV_DONE, 0, 8'd0);
    push(EV_GNT, 2, 8'h33); push(EV_DONE, 0, 8'd0);
    push(EV_GNT, 3, 8'h44); push(EV_DONE, 0, 8'd0);
    push(EV_GNT, 0, 8'h11); push(EV_DONE, 0, 8'd0);
    req_i = 4'b1111;
    for (int b = 0; b < 5; b++) run_byte(1, 1'b1, 1'b0);
    req_i = 4'b0000;
    repeat (3) @(negedge pclk_i);

    // Only requesters 1 and 3 enabled: they alternate.
    do_reset();
    chan_en_i = 4'b1010;
    push(EV_GNT, 1, 8'h22); push(EV_DONE, 0, 8'd0);
    push(EV_GNT, 3, 8'h44); push(EV_DONE, 0, 8'd0);
    push(EV_GNT, 1, 8'h22); push(EV_DONE, 0, 8'd0);
    push(EV_GNT, 3, 8'h44); push(EV_DONE, 0, 8'd0);
    req_i = 4'b1111;
    for (int b = 0; b < 4; b++) run_byte(0, 1'b1, 1'b0);
    req_i = 4'b0000;
    chan_en_i = 4'hF;
    repeat (3) @(negedge pclk_i);

    // Timeout of 10 with no done: err_o in the 10th clock after tx_en_o.
    do_reset();
    data_i = {8'h44, 8'h33, 8'h22, 8'h5A};
    timeout_i = 16'd10;
    push(EV_GNT, 0, 8'h5A); push(EV_ERR, 0, 8'd0);
    req_i = 4'b0001;
    run_byte(0, 1'b0, 1'b1);
    n = 0;
    while (!err_o && n < 40) begin @(negedge pclk_i); n++; end
    chk("timeout_clocks", 32'(n), 32'd10);
    chk("busy_after_err", 32'(busy_o), 32'd0);
    chk("err_no_done", 32'(done_o), 32'd0);
    repeat (3) @(negedge pclk_i);

    // tx_done_i on the timeout clock: done wins, no err.
    push(EV_GNT, 0, 8'h5A); push(EV_DONE, 0, 8'd0);
    req_i = 4'b0001;
    run_byte(9, 1'b1, 1'b1);
    repeat (3) @(negedge pclk_i);
    timeout_i = 16'd0;

    // Gap of 5: 5 GAP clocks, one IDLE clock, then grant -> 7 clocks after tx_done_i.
    do_reset();
    gap_i = 16'd5;
    push(EV_GNT, 0, 8'h5A); push(EV_DONE, 0, 8'd0);
    push(EV_GNT, 1, 8'h22); push(EV_DONE, 0, 8'd0);
    req_i = 4'b0011;
    run_byte(1, 1'b1, 1'b1);
    chk("busy_in_gap", 32'(busy_o), 32'd1);
    n = 1;
    while (gnt_o == 4'd0 && n < 40) begin @(negedge pclk_i); n++; end
    chk("gap_to_grant", 32'(n), 32'd7);
    run_byte(0, 1'b1, 1'b1);

    // Reset in the middle of GAP: busy drops at once, no further pulses.
    @(negedge pclk_i);
    push(EV_GNT, 0, 8'h5A); push(EV_DONE, 0, 8'd0);
    repeat (8) @(negedge pclk_i);
    req_i = 4'b0001;
    run_byte(0, 1'b1, 1'b1);
    @(negedge pclk_i);
    #2 prst_ni = 1'b0;
    #1;
    chk("rst_gap_busy", 32'(busy_o), 32'd0);
    chk("rst_gap_pulses", 32'({gnt_o, tx_en_o, done_o, err_o}), 32'd0);
    repeat (2) @(negedge pclk_i);
    prst_ni = 1'b1;
    repeat (10) @(negedge pclk_i);

    chk("queue_empty_end", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
